alu_pipe_div: RTL and testbench
===============================

// Module: alu_pipe_div
// PURPOSE
//  Parametrised successor to the 40-bit select-coded ALU: same 5-bit opcode map (add/sub/mul/div).
//  Adds a valid/ready input handshake, a single-cycle result-valid strobe and status flags.
//  Replaces the combinational divider with an iterative restoring divider (1 quotient bit/cycle).
//  Sits between operand registers and result writeback in the datapath test harness.
// PARAMETERS
//  WIDTH   40       operand/result width in bits (>=2)
//  OP_ADD  5'b00101 opcode: out = a + b
//  OP_SUB  5'b00110 opcode: out = a - b
//  OP_MUL  5'b01000 opcode: out = low WIDTH bits of a * b
//  OP_DIV  5'b01011 opcode: out = a / b, rem = a % b (unsigned)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  a          in   WIDTH  operand A (unsigned)
//  b          in   WIDTH  operand B (unsigned)
//  s          in   5      opcode select
//  in_valid   in   1      operands/opcode valid this cycle
//  in_ready   out  1      block can accept an op this cycle
//  out        out  WIDTH  result (sum/difference/product low half/quotient)
//  rem        out  WIDTH  division remainder; 0 for non-div ops
//  out_valid  out  1      one-cycle strobe: out/rem/flags updated
//  cv         out  1      add carry-out / sub borrow / mul high half non-zero
//  dz         out  1      divide by zero
//  err        out  1      opcode not in map
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; out, rem, out_valid, cv, dz, err = 0; in_ready=1 next cycle.
//  - FSM states IDLE, DIV. in_ready = (state==IDLE) && !rst.
//  - Accept = in_valid && in_ready at posedge; a, b, s captured at that edge only.
//  - IDLE, accept, s in {ADD,SUB,MUL}: out/cv registered at accepting edge; out_valid=1 the
//    following cycle (latency 1); rem=0, dz=0, err=0. Stay IDLE.
//  - ADD: {cv,out} = a+b (WIDTH+1 bits). SUB: out = (a-b) mod 2^WIDTH, cv = (a<b).
//  - MUL: full 2*WIDTH product; out = low WIDTH bits; cv = |high WIDTH bits.
//  - DIV, b!=0: load dividend/divisor/counter=WIDTH, go DIV; each cycle shift-subtract one bit
//    MSB first; after WIDTH iterations write out=quotient, rem=remainder, cv=0, go IDLE;
//    out_valid high exactly WIDTH+1 cycles after the accepting edge. in_ready=0 throughout DIV.
//  - DIV, b==0: no iteration; out = all ones, rem = a, dz=1, latency 1, stay IDLE.
//  - Illegal s: out and rem keep previous values; err=1, cv=0, dz=0; out_valid pulses, latency 1.
//  - Flags and out/rem hold until the next out_valid; out_valid is never high 2 cycles for one op.
//  - Back-to-back: in the cycle out_valid=1 after a 1-cycle op, in_ready=1; a new accept there
//    produces out_valid again next cycle (full throughput for add/sub/mul).
//  - in_valid while in_ready=0 is ignored (not queued); caller must hold it.
//  - a, b, s changes during DIV do not affect the result in flight.
//  - rst during DIV aborts: no out_valid for that op; reset values apply; rst wins over accept.
//  - WIDTH=1 not supported; counter width = clog2(WIDTH+1).
// TESTING (WIDTH=40)
//  1) a=0x0b, b=0x03, s=00101, pulse in_valid -> next cycle out=0x0e, out_valid=1, cv=0;
//     then s=00110 -> out=0x08, cv=0; s=01000 -> out=0x21, cv=0.
//  2) a=0x0b, b=0x03, s=01011 -> in_ready=0 for 40 cycles; out_valid at accept+41; out=3, rem=2.
//  3) a=0xFF_FFFF_FFFF, b=1, ADD -> out=0, cv=1; a=0, b=1, SUB -> out=0xFF_FFFF_FFFF, cv=1.
//  4) a=0x0b, b=0, DIV -> next cycle out=0xFF_FFFF_FFFF, rem=0x0b, dz=1, out_valid=1.
//  5) s=00111 after an ADD giving 0x0e -> out_valid=1, err=1, out stays 0x0e.
//  6) start DIV, assert rst at cycle 20 -> no out_valid, all outputs 0, in_ready=1 after reset;
//     new ADD 2+2 then gives out=4.

Source files
------------

// File: rtl/alu_pipe_div.sv
// Select-coded ALU with a valid/ready input handshake and a one-cycle result strobe.
// Add, sub and mul complete in one cycle. Divide uses an iterative restoring divider.
module alu_pipe_div #(
    parameter int         WIDTH  = 40,
    parameter logic [4:0] OP_ADD = 5'b00101,
    parameter logic [4:0] OP_SUB = 5'b00110,
    parameter logic [4:0] OP_MUL = 5'b01000,
    parameter logic [4:0] OP_DIV = 5'b01011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rem,
    output logic             out_valid,
    output logic             cv,
    output logic             dz,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, DIV} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               out_valid_q, out_valid_d;
    logic               cv_q, cv_d;
    logic               dz_q, dz_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   div_rem_q, div_rem_d;
    logic [WIDTH-1:0]   div_quo_q, div_quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign sum       = {1'b0, a} + {1'b0, b};
    assign prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // The partial remainder stays below the divisor, so bit WIDTH of the trial difference is its borrow.
    assign div_shift = {div_rem_q, div_quo_q[WIDTH-1]};
    assign div_sub   = div_shift - {1'b0, divisor_q};
    assign div_ge    = !div_sub[WIDTH];
    assign rem_next  = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {div_quo_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        rem_d       = rem_q;
        out_valid_d = 1'b0;
        cv_d        = cv_q;
        dz_d        = dz_q;
        err_d       = err_q;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (s)
                        OP_ADD: begin
                            {cv_d, out_d} = sum;
                            rem_d = '0; dz_d = 1'b0; err_d = 1'b0; out_valid_d = 1'b1;
                        end
                        OP_SUB: begin
                            out_d = a - b;
                            cv_d  = (a < b);
                            rem_d = '0; dz_d = 1'b0; err_d = 1'b0; out_valid_d = 1'b1;
                        end
                        OP_MUL: begin
                            out_d = prod[WIDTH-1:0];
                            cv_d  = |prod[2*WIDTH-1:WIDTH];
                            rem_d = '0; dz_d = 1'b0; err_d = 1'b0; out_valid_d = 1'b1;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                out_d = '1; rem_d = a;
                                cv_d = 1'b0; dz_d = 1'b1; err_d = 1'b0; out_valid_d = 1'b1;
                            end else begin
                                div_rem_d = '0;
                                div_quo_d = a;
                                divisor_d = b;
                                cnt_d     = CW'(WIDTH);
                                state_d   = DIV;
                            end
                        end
                        default: begin
                            cv_d = 1'b0; dz_d = 1'b0; err_d = 1'b1; out_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            DIV: begin
                div_rem_d = rem_next;
                div_quo_d = quo_next;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_d = quo_next; rem_d = rem_next;
                    cv_d = 1'b0; dz_d = 1'b0; err_d = 1'b0; out_valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            cv_q        <= 1'b0;
            dz_q        <= 1'b0;
            err_q       <= 1'b0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            cv_q        <= cv_d;
            dz_q        <= dz_d;
            err_q       <= err_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out       = out_q;
    assign rem       = rem_q;
    assign out_valid = out_valid_q;
    assign cv        = cv_q;
    assign dz        = dz_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe_div.sv
// Directed bench for alu_pipe_div at WIDTH=40: single-cycle vector table plus
// hand-written divide, back-to-back and reset-abort sequences.
module tb_alu_pipe_div;

    localparam int         W      = 40;
    localparam logic [4:0] OP_ADD = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01011;
    localparam logic [W-1:0] ALL1 = 40'hFF_FFFF_FFFF;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   s;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic [W-1:0] rem;
    logic         out_valid;
    logic         cv;
    logic         dz;
    logic         err;

    int checks = 0;
    int errors = 0;

    alu_pipe_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .rem       (rem),
        .out_valid (out_valid),
        .cv        (cv),
        .dz        (dz),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   s;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_rem;
        logic         exp_cv;
        logic         exp_dz;
        logic         exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Presents one op at the negedge, lets the next posedge accept it, and returns #1 after that edge.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [4:0] vs);
        @(negedge clk);
        a = va; b = vb; s = vs; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic checkAll(input string name, input logic [W-1:0] eo, input logic [W-1:0] er,
                            input logic ecv, input logic edz, input logic eerr);
        checkOutput({name, ".out_valid"}, 64'(out_valid), 64'(1));
        checkOutput({name, ".out"}, 64'(out), 64'(eo));
        checkOutput({name, ".rem"}, 64'(rem), 64'(er));
        checkOutput({name, ".cv"}, 64'(cv), 64'(ecv));
        checkOutput({name, ".dz"}, 64'(dz), 64'(edz));
        checkOutput({name, ".err"}, 64'(err), 64'(eerr));
    endtask

    // Runs a non-zero divide, scrambling the inputs mid-flight; returns at the result cycle.
    task automatic runDiv(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
        int got;
        int busy;
        got  = -1;
        busy = 0;
        applyStimulus(va, vb, OP_DIV);
        checkOutput({name, ".no_early_valid"}, 64'(out_valid), 64'(0));
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == 5) begin
                a = 40'h12_3456_789A; b = 40'h1; s = OP_ADD; in_valid = 1'b1;
            end
            if (k == 10) in_valid = 1'b0;
            if (out_valid) begin
                got = k;
                break;
            end
            if (!in_ready) busy++;
        end
        checkOutput({name, ".latency"}, 64'(got), 64'(40));
        checkOutput({name, ".busy_cycles"}, 64'(busy), 64'(40));
        checkAll(name, eq, er, 1'b0, 1'b0, 1'b0);
        checkOutput({name, ".ready_after"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        checkOutput({name, ".single_pulse"}, 64'(out_valid), 64'(0));
        checkOutput({name, ".out_hold"}, 64'(out), 64'(eq));
    endtask

    initial begin
        int seen;

        rst = 1'b1; a = '0; b = '0; s = '0; in_valid = 1'b0;

        vecs.push_back('{"add_basic", 40'h0b, 40'h03, OP_ADD, 40'h0e, 40'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_basic", 40'h0b, 40'h03, OP_SUB, 40'h08, 40'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"mul_basic", 40'h0b, 40'h03, OP_MUL, 40'h21, 40'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"illegal_after_mul", 40'h5, 40'h5, 5'b11111, 40'h21, 40'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"add_carry", ALL1, 40'h1, OP_ADD, 40'h0, 40'h0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_borrow", 40'h0, 40'h1, OP_SUB, ALL1, 40'h0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"div_by_zero", 40'h0b, 40'h0, OP_DIV, ALL1, 40'h0b, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"add_to_0e", 40'h05, 40'h09, OP_ADD, 40'h0e, 40'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"illegal_00111", 40'h77, 40'h1, 5'b00111, 40'h0e, 40'h0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"mul_overflow", 40'h01_0000_0000, 40'h100, OP_MUL, 40'h0, 40'h0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"mul_mid", 40'h12345, 40'h10, OP_MUL, 40'h123450, 40'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_nonzero", 40'h100, 40'h1, OP_SUB, 40'hFF, 40'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_equal", 40'h7, 40'h7, OP_SUB, 40'h0, 40'h0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"add_msb_carry", 40'h80_0000_0000, 40'h80_0000_0000, OP_ADD, 40'h0, 40'h0, 1'b1, 1'b0, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.out", 64'(out), 64'(0));
        checkOutput("reset.rem", 64'(rem), 64'(0));
        checkOutput("reset.out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset.flags", 64'({cv, dz, err}), 64'(0));
        checkOutput("reset.in_ready_during", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        checkOutput("reset.in_ready_after", 64'(in_ready), 64'(1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s);
            checkAll(vecs[i].name, vecs[i].exp_out, vecs[i].exp_rem,
                     vecs[i].exp_cv, vecs[i].exp_dz, vecs[i].exp_err);
        end

        @(posedge clk);
        #1;
        checkOutput("idle.out_valid_low", 64'(out_valid), 64'(0));
        checkOutput("idle.out_hold", 64'(out), 64'(0));

        runDiv("div_basic", 40'h0b, 40'h03, 40'h3, 40'h2);
        runDiv("div_large", ALL1, 40'h10, 40'h0F_FFFF_FFFF, 40'hF);
        runDiv("div_exact", 40'h64, 40'h64, 40'h1, 40'h0);

        // Back-to-back single-cycle ops with in_valid held high.
        applyStimulus(40'h1, 40'h2, OP_ADD);
        checkAll("b2b_first", 40'h3, 40'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("b2b.in_ready", 64'(in_ready), 64'(1));
        a = 40'h5; b = 40'h1; s = OP_SUB; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkAll("b2b_second", 40'h4, 40'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("b2b.no_extra_pulse", 64'(out_valid), 64'(0));
        checkOutput("b2b.out_hold", 64'(out), 64'(4));

        // Reset during a divide aborts it; rst also wins over a simultaneous request.
        applyStimulus(40'h0b, 40'h03, OP_DIV);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; a = 40'h2; b = 40'h2; s = OP_ADD; in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort.in_ready_in_rst", 64'(in_ready), 64'(0));
        checkOutput("abort.out", 64'(out), 64'(0));
        checkOutput("abort.rem", 64'(rem), 64'(0));
        checkOutput("abort.out_valid", 64'(out_valid), 64'(0));
        checkOutput("abort.flags", 64'({cv, dz, err}), 64'(0));
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("abort.in_ready_after", 64'(in_ready), 64'(1));
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("abort.no_result", 64'(seen), 64'(0));
        applyStimulus(40'h2, 40'h2, OP_ADD);
        checkAll("abort.add_after", 40'h4, 40'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
